// File: rtl/spart_driver.sv
// SPART bus master: programs the baud divisor from br_cfg, then echoes each received byte.
// Latency: bus cycle issued the cycle after the deciding edge; echo write 2 cycles after the read.
// Backpressure: waits in WAIT_TX while tbr=0; br_cfg changes are only acted on from IDLE.
module spart_driver #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus
);

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        IDLE,
        RX,
        WAIT_TX,
        TX
    } state_t;

    localparam logic [15:0] DIV_4800  = 16'(CLK_HZ / (16 * 4800) - 1);
    localparam logic [15:0] DIV_9600  = 16'(CLK_HZ / (16 * 9600) - 1);
    localparam logic [15:0] DIV_19200 = 16'(CLK_HZ / (16 * 19200) - 1);
    localparam logic [15:0] DIV_38400 = 16'(CLK_HZ / (16 * 38400) - 1);

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_DB_L = 2'b10;
    localparam logic [1:0] ADDR_DB_H = 2'b11;

    function automatic logic [15:0] div_of(input logic [1:0] cfg);
        case (cfg)
            2'b00:   div_of = DIV_4800;
            2'b01:   div_of = DIV_9600;
            2'b10:   div_of = DIV_19200;
            default: div_of = DIV_38400;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  cfg_q, cfg_d;
    logic [7:0]  char_q;
    logic [7:0]  dat_q;
    logic        iocs_d, iorw_d;
    logic [1:0]  ioaddr_d;
    logic [7:0]  dat_d;
    logic [15:0] div_d;

    // Bus outputs are registered from the state being entered, so the state
    // register always names the access currently on the bus. CFG_LO straight
    // out of reset has not issued its write yet; iocs tells the two apart.
    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        iocs_d   = 1'b0;
        iorw_d   = 1'b1;
        ioaddr_d = ADDR_BUF;
        dat_d    = 8'h00;
        div_d    = 16'h0000;

        case (state_q)
            CFG_LO:  if (iocs) state_d = CFG_HI;
            CFG_HI:  state_d = IDLE;
            IDLE: begin
                if (br_cfg != cfg_q) state_d = CFG_LO;
                else if (rda)        state_d = RX;
            end
            RX:      state_d = WAIT_TX;
            WAIT_TX: if (tbr) state_d = TX;
            TX:      state_d = IDLE;
            default: state_d = CFG_LO;
        endcase

        case (state_d)
            CFG_LO: begin
                cfg_d    = br_cfg;
                div_d    = div_of(br_cfg);
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = ADDR_DB_L;
                dat_d    = div_d[7:0];
            end
            CFG_HI: begin
                div_d    = div_of(cfg_q);
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = ADDR_DB_H;
                dat_d    = div_d[15:8];
            end
            RX: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b1;
                ioaddr_d = ADDR_BUF;
            end
            TX: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = ADDR_BUF;
                dat_d    = char_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CFG_LO;
            cfg_q   <= br_cfg;
            char_q  <= 8'h00;
            dat_q   <= 8'h00;
            iocs    <= 1'b0;
            iorw    <= 1'b1;
            ioaddr  <= ADDR_BUF;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            dat_q   <= dat_d;
            iocs    <= iocs_d;
            iorw    <= iorw_d;
            ioaddr  <= ioaddr_d;
            // SPART drives the read data combinationally during the RX cycle.
            if (state_q == RX) char_q <= databus;
        end
    end

    assign databus = (iocs && !iorw) ? dat_q : 8'hzz;

endmodule
